target_bus_tx: RTL and testbench

// - Target-side SDA transmit engine; directly downstream of the ENTDAA and other CCC FSMs that issue bit/byte TX requests.
// - Serialises one bit or one byte (MSB first) onto SDA, timed to SCL edges, and holds data for tHD_DAT after each SCL fall.
// - Samples SDA on SCL rise in open-drain mode to detect arbitration loss (ENTDAA ID phase).
// - Pulses done once per completed request.

---
 rtl/target_bus_tx.sv | 247 ++++++++++++++++++++++++
 tb/tb_target_bus_tx.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/target_bus_tx.sv
// Purpose : target-side SDA transmit engine; serialises one bit or one byte (MSB first) timed to SCL.
// Latency : a bit is driven on the first clk with SCL low and the tHD_DAT hold expired; done_o on the SCL fall ending the last bit.
// Backpress: requests are level-held until done_o; new requests are accepted only in Idle/HoldOut (never in the done_o cycle).
//
// Optional feature macro: I3C_TX_TBIT_EN -- byte requests append a 9th odd-parity T-bit, driven push-pull.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   req_bit_i / req_byte_i   level requests (bit wins if both); req_value_i and sel_od_pp_i latched on accept
//   done_o                   one-cycle pulse when a request completes
//   arbitration_lost_o       sticky: open-drain '1' read back as '0'; cleared on the next accept
//   scl_i, scl_posedge_i, scl_negedge_i, sda_i   synchronised bus observation
//   bus_stop_det_i, bus_rstart_det_i             abort the transfer (back to Idle, no done_o)
//   sda_o, sel_od_pp_o       SDA drive value (1 = released in OD) and pad mode (0 = OD, 1 = PP)

module target_bus_tx #(
  parameter int unsigned T_HD_DAT_CYCLES = 3,
  parameter int unsigned HD_CNT_W        = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_bit_i,
  input  logic       req_byte_i,
  input  logic [7:0] req_value_i,
  input  logic       sel_od_pp_i,
  output logic       done_o,
  output logic       arbitration_lost_o,
  input  logic       scl_i,
  input  logic       scl_posedge_i,
  input  logic       scl_negedge_i,
  input  logic       sda_i,
  input  logic       bus_stop_det_i,
  input  logic       bus_rstart_det_i,
  output logic       sda_o,
  output logic       sel_od_pp_o
);

`ifdef I3C_TX_TBIT_EN
  localparam int unsigned SH_W = 9;
  localparam logic [3:0] BYTE_BITS = 4'd9;
`else
  localparam int unsigned SH_W = 8;
  localparam logic [3:0] BYTE_BITS = 4'd8;
`endif

  localparam logic [HD_CNT_W-1:0] HD_MAX = HD_CNT_W'(T_HD_DAT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_HIGH    = 3'd3,
    ST_HOLDOUT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [HD_CNT_W-1:0] hd_cnt_q, hd_cnt_d;
  logic [SH_W-1:0]     shift_q, shift_d;
  logic [3:0]          bits_q, bits_d;
  logic                od_pp_q, od_pp_d;
  logic                sda_q, sda_d;
  logic                sel_q, sel_d;
  logic                done_q, done_d;
  logic                arb_q, arb_d;
`ifdef I3C_TX_TBIT_EN
  logic                is_byte_q, is_byte_d;
`endif

  logic            hold_ok;
  logic            req_any;
  logic            accept;
  logic            abort;
  logic            cur_bit;
  logic            tbit_now;
  logic [SH_W-1:0] load_shift;
  logic [3:0]      load_bits;

  assign req_any = req_bit_i | req_byte_i;
  assign abort   = bus_stop_det_i | bus_rstart_det_i;
  assign cur_bit = shift_q[SH_W-1];

  // Acceptance is blocked in the done_o cycle so a requester still holding
  // the finished request's level is not serviced twice.
  assign accept = req_any &&
                  ((state_q == ST_IDLE) || ((state_q == ST_HOLDOUT) && !done_q));

`ifdef I3C_TX_TBIT_EN
  // The T-bit is the last bit of a byte request; it is always driven push-pull.
  assign tbit_now = is_byte_q && (bits_q == 4'd1);
`else
  assign tbit_now = 1'b0;
`endif

  // Load image: the bit to send first always sits in the MSB of the shifter.
  always_comb begin
    load_shift = '0;
    load_bits  = BYTE_BITS;
    if (req_bit_i) begin
      load_shift[SH_W-1] = req_value_i[0];
      load_bits          = 4'd1;
    end else begin
`ifdef I3C_TX_TBIT_EN
      load_shift = {req_value_i, ~^req_value_i};
`else
      load_shift = req_value_i;
`endif
    end
  end

  // Hold counter: restarts on every SCL fall and saturates at T_HD_DAT_CYCLES.
  // hold_ok looks at the next count so that the new bit appears on exactly the
  // T_HD_DAT_CYCLES-th clock edge after the fall was seen, and a fall in the
  // current cycle always re-arms the hold.
  always_comb begin
    hd_cnt_d = hd_cnt_q;
    if (scl_negedge_i) begin
      hd_cnt_d = '0;
    end else if (hd_cnt_q != HD_MAX) begin
      hd_cnt_d = hd_cnt_q + HD_CNT_W'(1);
    end
  end

  assign hold_ok = (hd_cnt_d == HD_MAX);

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bits_d  = bits_q;
    od_pp_d = od_pp_q;
    sda_d   = sda_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    arb_d   = arb_q;
`ifdef I3C_TX_TBIT_EN
    is_byte_d = is_byte_q;
`endif

    case (state_q)
      ST_IDLE: begin
        sda_d = 1'b1;
        sel_d = 1'b0;
      end

      ST_SETUP: begin
        // Previous SDA value stays on the wire until the hold window expires.
        if (!scl_i && hold_ok) begin
          state_d = ST_DRIVE;
          sda_d   = arb_q ? 1'b1 : cur_bit;
          sel_d   = tbit_now ? 1'b1 : od_pp_q;
        end
      end

      ST_DRIVE: begin
        if (scl_posedge_i) begin
          // sel_q is the effective pad mode, so a push-pull T-bit is never checked.
          if (!sel_q && cur_bit && !sda_i) begin
            arb_d = 1'b1;
          end
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (scl_negedge_i) begin
          if (bits_q == 4'd1) begin
            done_d  = 1'b1;
            state_d = ST_HOLDOUT;
          end else begin
            shift_d = {shift_q[SH_W-2:0], 1'b0};
            bits_d  = bits_q - 4'd1;
            state_d = ST_SETUP;
          end
        end
      end

      ST_HOLDOUT: begin
        if (!accept && hold_ok) begin
          state_d = ST_IDLE;
          sda_d   = 1'b1;
          sel_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        sda_d   = 1'b1;
        sel_d   = 1'b0;
      end
    endcase

    if (accept) begin
      state_d = ST_SETUP;
      shift_d = load_shift;
      bits_d  = load_bits;
      od_pp_d = sel_od_pp_i;
      arb_d   = 1'b0;
`ifdef I3C_TX_TBIT_EN
      is_byte_d = !req_bit_i;
`endif
    end

    // STOP / Repeated START win over everything else; arbitration flag is kept.
    if (abort) begin
      state_d = ST_IDLE;
      sda_d   = 1'b1;
      sel_d   = 1'b0;
      done_d  = 1'b0;
      arb_d   = arb_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      hd_cnt_q <= HD_MAX;
      shift_q  <= '0;
      bits_q   <= '0;
      od_pp_q  <= 1'b0;
      sda_q    <= 1'b1;
      sel_q    <= 1'b0;
      done_q   <= 1'b0;
      arb_q    <= 1'b0;
`ifdef I3C_TX_TBIT_EN
      is_byte_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      hd_cnt_q <= hd_cnt_d;
      shift_q  <= shift_d;
      bits_q   <= bits_d;
      od_pp_q  <= od_pp_d;
      sda_q    <= sda_d;
      sel_q    <= sel_d;
      done_q   <= done_d;
      arb_q    <= arb_d;
`ifdef I3C_TX_TBIT_EN
      is_byte_q <= is_byte_d;
`endif
    end
  end

  assign sda_o              = sda_q;
  assign sel_od_pp_o        = sel_q;
  assign done_o             = done_q;
  assign arbitration_lost_o = arb_q;

endmodule

// File: tb/tb_target_bus_tx.sv
// Purpose : directed self-checking bench for target_bus_tx (T_HD_DAT_CYCLES = 3).
// Latency : inputs change 1 time unit after a clk rise; outputs are checked at the same point.
// Backpress: requester behaviour is modelled by dropping the request level after done_o.

module tb_target_bus_tx;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_bit_i;
  logic       req_byte_i;
  logic [7:0] req_value_i;
  logic       sel_od_pp_i;
  logic       done_o;
  logic       arbitration_lost_o;
  logic       scl_i;
  logic       scl_posedge_i;
  logic       scl_negedge_i;
  logic       sda_i;
  logic       bus_stop_det_i;
  logic       bus_rstart_det_i;
  logic       sda_o;
  logic       sel_od_pp_o;

  int errors = 0;
  int checks = 0;

`ifdef I3C_TX_TBIT_EN
  localparam bit TBIT = 1'b1;
`else
  localparam bit TBIT = 1'b0;
`endif

  target_bus_tx #(
    .T_HD_DAT_CYCLES(3),
    .HD_CNT_W       (8)
  ) dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .req_bit_i         (req_bit_i),
    .req_byte_i        (req_byte_i),
    .req_value_i       (req_value_i),
    .sel_od_pp_i       (sel_od_pp_i),
    .done_o            (done_o),
    .arbitration_lost_o(arbitration_lost_o),
    .scl_i             (scl_i),
    .scl_posedge_i     (scl_posedge_i),
    .scl_negedge_i     (scl_negedge_i),
    .sda_i             (sda_i),
    .bus_stop_det_i    (bus_stop_det_i),
    .bus_rstart_det_i  (bus_rstart_det_i),
    .sda_o             (sda_o),
    .sel_od_pp_o       (sel_od_pp_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic scl_fall();
    scl_i         = 1'b0;
    scl_negedge_i = 1'b1;
    step();
    scl_negedge_i = 1'b0;
  endtask

  // One full SCL period starting just after a fall: wait out the hold,
  // check the driven bit, rise (bus reads bus_sda), high, fall, check done_o.
  task automatic bit_cycle(input string tag, input logic exp_sda, input logic exp_sel,
                           input logic bus_sda, input logic exp_arb, input logic exp_done);
    step();
    step();
    step();
    chk({tag, "_sda"}, sda_o, exp_sda);
    chk({tag, "_sel"}, sel_od_pp_o, exp_sel);
    sda_i         = bus_sda;
    scl_i         = 1'b1;
    scl_posedge_i = 1'b1;
    step();
    scl_posedge_i = 1'b0;
    chk({tag, "_arb"}, arbitration_lost_o, exp_arb);
    step();
    scl_fall();
    sda_i = 1'b1;
    chk({tag, "_done"}, done_o, exp_done);
  endtask

  initial begin
    logic [7:0] v;

    rst_i            = 1'b1;
    req_bit_i        = 1'b0;
    req_byte_i       = 1'b0;
    req_value_i      = 8'h00;
    sel_od_pp_i      = 1'b0;
    scl_i            = 1'b1;
    scl_posedge_i    = 1'b0;
    scl_negedge_i    = 1'b0;
    sda_i            = 1'b1;
    bus_stop_det_i   = 1'b0;
    bus_rstart_det_i = 1'b0;
    step();
    step();
    chk("rst_sda", sda_o, 1'b1);
    chk("rst_sel", sel_od_pp_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_arb", arbitration_lost_o, 1'b0);
    rst_i = 1'b0;
    step();

    // Single OD bit of value 0: drive lands 3 clks after the fall, release 3 clks after done.
    req_bit_i   = 1'b1;
    req_value_i = 8'h00;
    sel_od_pp_i = 1'b0;
    step();
    chk("b0_accept_sda", sda_o, 1'b1);
    scl_fall();
    step();
    step();
    chk("b0_hold_sda", sda_o, 1'b1);
    step();
    chk("b0_drive_sda", sda_o, 1'b0);
    chk("b0_drive_sel", sel_od_pp_o, 1'b0);
    scl_i = 1'b1; scl_posedge_i = 1'b1;
    step();
    scl_posedge_i = 1'b0;
    step();
    scl_fall();
    chk("b0_done", done_o, 1'b1);
    chk("b0_done_sda", sda_o, 1'b0);
    req_bit_i = 1'b0;
    step();
    chk("b0_done_pulse", done_o, 1'b0);
    step();
    chk("b0_holdout_sda", sda_o, 1'b0);
    step();
    chk("b0_release_sda", sda_o, 1'b1);

    // Byte 0xA5 push-pull; bus reads 0 every bit, which must not flag arbitration.
    v           = 8'hA5;
    scl_i       = 1'b1;
    req_byte_i  = 1'b1;
    req_value_i = v;
    sel_od_pp_i = 1'b1;
    step();
    scl_fall();
    for (int i = 7; i >= 0; i--) begin
      bit_cycle($sformatf("a5_b%0d", i), v[i], 1'b1, 1'b0, 1'b0, (i == 0) && !TBIT);
    end
    if (TBIT) begin
      bit_cycle("a5_tbit", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    // Back-to-back request arriving the cycle after done_o, accepted in HoldOut.
    req_byte_i = 1'b0;
    step();
    chk("a5_done_pulse", done_o, 1'b0);
    req_bit_i   = 1'b1;
    req_value_i = 8'h00;
    sel_od_pp_i = 1'b0;
    step();
    chk("hoa_held_sda", sda_o, 1'b1);
    step();
    chk("hoa_drive_sda", sda_o, 1'b0);
    chk("hoa_drive_sel", sel_od_pp_o, 1'b0);
    scl_i = 1'b1; scl_posedge_i = 1'b1;
    step();
    scl_posedge_i = 1'b0;
    step();
    scl_fall();
    chk("hoa_done", done_o, 1'b1);
    req_bit_i = 1'b0;
    step(); step(); step();
    chk("hoa_release_sda", sda_o, 1'b1);

    // Byte 0x85 OD: first bit 1 read back as 0 -> lost; remaining bits released.
    v           = 8'h85;
    scl_i       = 1'b1;
    req_byte_i  = 1'b1;
    req_value_i = v;
    sel_od_pp_i = 1'b0;
    step();
    scl_fall();
    bit_cycle("arb_b7", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      bit_cycle($sformatf("arb_b%0d", i), 1'b1, 1'b0, 1'b1, 1'b1, (i == 0) && !TBIT);
    end
    if (TBIT) begin
      bit_cycle("arb_tbit", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    end
    req_byte_i = 1'b0;
    step(); step(); step();
    chk("arb_sticky_idle", arbitration_lost_o, 1'b1);

    // Byte 0xFF OD aborted by STOP during the 4th bit; arbitration cleared by the accept.
    scl_i       = 1'b1;
    req_byte_i  = 1'b1;
    req_value_i = 8'hFF;
    sel_od_pp_i = 1'b0;
    step();
    chk("stop_arb_cleared", arbitration_lost_o, 1'b0);
    scl_fall();
    for (int i = 7; i >= 5; i--) begin
      bit_cycle($sformatf("stop_b%0d", i), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    step(); step(); step();
    bus_stop_det_i = 1'b1;
    step();
    bus_stop_det_i = 1'b0;
    req_byte_i     = 1'b0;
    chk("stop_sda", sda_o, 1'b1);
    chk("stop_done", done_o, 1'b0);
    step();
    chk("stop_done_after", done_o, 1'b0);
    // Next bit request after the abort is serviced normally.
    scl_i       = 1'b1;
    req_bit_i   = 1'b1;
    req_value_i = 8'h00;
    step();
    scl_fall();
    bit_cycle("post_stop", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    req_bit_i = 1'b0;
    step(); step(); step();

    // Byte 0x00 PP aborted by Repeated START while driving 0.
    scl_i       = 1'b1;
    req_byte_i  = 1'b1;
    req_value_i = 8'h00;
    sel_od_pp_i = 1'b1;
    step();
    scl_fall();
    bit_cycle("rs_b7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    chk("rs_pre_sda", sda_o, 1'b0);
    bus_rstart_det_i = 1'b1;
    scl_i            = 1'b1;
    scl_posedge_i    = 1'b1;
    step();
    bus_rstart_det_i = 1'b0;
    scl_posedge_i    = 1'b0;
    req_byte_i       = 1'b0;
    chk("rs_sda", sda_o, 1'b1);
    chk("rs_sel", sel_od_pp_o, 1'b0);
    chk("rs_done", done_o, 1'b0);

    // Reset while driving 0.
    step();
    req_bit_i   = 1'b1;
    req_value_i = 8'h00;
    sel_od_pp_i = 1'b0;
    step();
    scl_fall();
    step(); step(); step();
    chk("rstmid_pre_sda", sda_o, 1'b0);
    rst_i = 1'b1;
    step();
    rst_i     = 1'b0;
    req_bit_i = 1'b0;
    chk("rstmid_sda", sda_o, 1'b1);
    chk("rstmid_done", done_o, 1'b0);
    chk("rstmid_sel", sel_od_pp_o, 1'b0);
    step();
    chk("rstmid_idle_sda", sda_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
